fifo_read_port: RTL

//  Read-side engine for the 8-deep FIFO. Issues rd pops to the FIFO controller and captures r_data.
//  r_data comes from the register file with a 1-cycle registered read latency.

---
 rtl/fifo_read_port_pkg.sv | 11 +
 rtl/fifo_read_port_skid.sv | 56 +++++
 rtl/fifo_read_port.sv | 77 +++++++
 3 files changed

// File: rtl/fifo_read_port_pkg.sv
// Shared definitions for the FIFO read-side engine.
// Default widths and the output-buffer occupancy type.
package fifo_read_port_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_read_port_skid.sv
// Two-entry output buffer with head pointer and occupancy count.
// Ports: i_push/i_data write at tail, i_pop advances head,
// i_clr empties the buffer, o_data is the head word, o_occ the fill level.
module fifo_read_port_skid
    import fifo_read_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output occ_t              o_occ
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_head;
    occ_t              r_occ;

    logic w_pop;
    logic w_push;
    logic w_tail;

    assign w_pop  = i_pop & (r_occ != 2'd0);
    assign w_push = i_push & ~i_clr & (r_occ != occ_t'(SKID_DEPTH));
    // Tail is the head slot when empty, the other slot when one word is held.
    assign w_tail = r_head ^ r_occ[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_mem[w_tail] <= i_data;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (i_clr) begin
                r_occ <= '0;
            end else begin
                r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    assign o_data = r_mem[r_head];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_read_port.sv
// Read-side engine: pops the FIFO, captures registered read data,
// and streams words out through a 2-entry buffer (valid/ready).
// Ports: empty/rd/r_data to the FIFO, flush discards buffered and
// in-flight words, m_* is the output stream, occ the buffer fill,
// word_cnt the wrapping count of completed output transfers.
module fifo_read_port
    import fifo_read_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              empty,
    output logic              rd,
    input  logic [DATA_W-1:0] r_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  word_cnt
);

    logic             r_inflight;
    logic             r_discard;
    logic [CNT_W-1:0] r_word_cnt;

    occ_t             w_occ;
    logic             w_pop;
    logic             w_capture;
    logic [2:0]       w_load;

    assign m_valid = (w_occ != 2'd0);
    assign w_pop   = m_valid & m_ready;

    // Words that will be held after this edge if we do not pop again.
    assign w_load = {1'b0, w_occ}
                  + {2'b00, r_inflight}
                  - {2'b00, w_pop};

    assign rd = reset & ~empty & ~flush & (w_load < 3'd2);

    // A landing word is dropped if a flush is active now or was last cycle.
    assign w_capture = r_inflight & ~r_discard & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= rd;
            r_discard  <= flush;
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    fifo_read_port_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (flush),
        .i_push  (w_capture),
        .i_data  (r_data),
        .i_pop   (w_pop),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    assign occ      = w_occ;
    assign word_cnt = r_word_cnt;

endmodule
